// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle between the ALU control sequencer
// (master) and the iterative divider (slave).
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one trial subtraction per clock,
// WIDTH iterations per operation, start/busy/done handshake.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    seq_divider_if.slave  io_bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_rem_sh;
    logic [WIDTH-1:0] w_quo_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_accept  = io_bus.start && (r_state != S_RUN);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    // Partial remainder stays below 2^k after k steps, so the shifted value fits WIDTH bits.
    assign w_rem_sh  = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    assign w_quo_sh  = {r_quo[WIDTH-2:0], 1'b0};
    assign w_trial   = {1'b0, w_rem_sh} - {1'b0, r_divisor};
    assign w_borrow  = w_trial[WIDTH];
    assign w_rem_nxt = w_borrow ? w_rem_sh : w_trial[WIDTH-1:0];
    assign w_quo_nxt = {w_quo_sh[WIDTH-1:1], ~w_borrow};

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_rem         <= '0;
            r_quo         <= '0;
            r_divisor     <= '0;
            r_cnt         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_divisor <= io_bus.divisor;
                        r_rem     <= '0;
                        r_quo     <= io_bus.dividend;
                        r_cnt     <= '0;
                        r_state   <= S_RUN;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_divisor == '0) begin
                        // Zero divisor: r_quo still holds the captured dividend.
                        r_quotient    <= '1;
                        r_remainder   <= r_quo;
                        r_div_by_zero <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_quotient    <= w_quo_nxt;
                            r_remainder   <= w_rem_nxt;
                            r_div_by_zero <= 1'b0;
                            r_state       <= S_DONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.busy        = (r_state == S_RUN);
    assign io_bus.done        = (r_state == S_DONE);
    assign io_bus.quotient    = r_quotient;
    assign io_bus.remainder   = r_remainder;
    assign io_bus.div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and reference-model checks for seq_divider at WIDTH=8.
module tb_seq_divider;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next rising edge (E0).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    // Counts negedges until done, with a bound so a stuck DUT still reaches the summary.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (!bus.done && cycles < 40) begin
            busy_cnt += int'(bus.busy);
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold);
        int          cyc, bcnt, lat;
        logic [W-1:0] eq, er;
        logic        edz;
        if (b == '0) begin
            eq = '1; er = a; edz = 1'b1; lat = 1;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0; lat = W;
        end
        launch(a, b);
        wait_done(cyc, bcnt);
        check({tag, " latency"}, cyc, lat);
        check({tag, " busy_cycles"}, bcnt, lat);
        check({tag, " quotient"}, bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        check({tag, " div_by_zero"}, bus.div_by_zero, edz);
        check({tag, " busy_at_done"}, bus.busy, 0);
        if (hold) begin
            @(negedge clk);
            check({tag, " done_width"}, bus.done, 0);
            repeat (2) @(negedge clk);
            check({tag, " hold_q"}, bus.quotient, eq);
            check({tag, " hold_r"}, bus.remainder, er);
            check({tag, " hold_dz"}, bus.div_by_zero, edz);
            check({tag, " idle_busy"}, bus.busy, 0);
        end
    endtask

    initial begin
        int cyc, bcnt;
        logic [W-1:0] a, b;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst quotient", bus.quotient, 0);
        check("rst remainder", bus.remainder, 0);
        check("rst dz", bus.div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic operation and boundaries
        run_op("100/7", 8'd100, 8'd7, 1'b1);
        run_op("255/1", 8'd255, 8'd1, 1'b1);
        run_op("5/9", 8'd5, 8'd9, 1'b1);
        run_op("255/255", 8'd255, 8'd255, 1'b1);
        run_op("0/3", 8'd0, 8'd3, 1'b1);

        // Divide by zero, then a back-to-back normal op from the DONE cycle
        run_op("0/0", 8'd0, 8'd0, 1'b1);
        run_op("77/0", 8'd77, 8'd0, 1'b0);
        run_op("10/3", 8'd10, 8'd3, 1'b1);

        // start during RUN is ignored; start in DONE is accepted
        launch(8'd200, 8'd10);
        repeat (2) @(negedge clk);
        bus.dividend = 8'd9;
        bus.divisor  = 8'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done(cyc, bcnt);
        check("ignore latency", cyc, 5);
        check("ignore quotient", bus.quotient, 20);
        check("ignore remainder", bus.remainder, 0);
        run_op("b2b 9/2", 8'd9, 8'd2, 1'b1);

        // Asynchronous reset mid-operation
        launch(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        check("pre_rst busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("arst busy", bus.busy, 0);
        check("arst done", bus.done, 0);
        check("arst quotient", bus.quotient, 0);
        check("arst remainder", bus.remainder, 0);
        check("arst dz", bus.div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("post_rst 200/10", 8'd200, 8'd10, 1'b1);

        // Reference-model sweep
        for (int i = 0; i < 300; i++) begin
            a = W'($urandom_range(0, 255));
            case (i % 5)
                0:       b = W'(1 << $urandom_range(0, 7));
                1:       b = W'($urandom_range(int'(a), 255));
                2:       b = (i % 25 == 2) ? '0 : W'($urandom_range(1, 15));
                default: b = W'($urandom_range(0, 255));
            endcase
            run_op($sformatf("rnd%0d %0d/%0d", i, a, b), a, b, (i % 10) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
